// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: UART receiver with built-in oversampling tick generator,
// 2-of-3 majority-vote bit sampling, false-start rejection, optional parity
// and 1 or 2 stop bits. A frame completes at the vote point of its last stop
// bit, so back-to-back frames with short stop bits are accepted.
// Optional feature macro: UART_RX_BREAK_DETECT_EN (break_det strobe).
module uart_rx_oversampled #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 system_clk,
    input  logic                 rst,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           flag_state,
    output logic                 break_det
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W     = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_VOTE_A = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_VOTE_B = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0]   S_VOTE_C = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0]   S_END    = S_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 sync1;
    logic                 sync2;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [S_W-1:0]       s_cnt;
    logic                 vote_a;
    logic                 vote_b;
    logic                 vote;
    logic                 vote_pt;
    logic                 bit_end;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 ferr_acc;
    logic                 armed;
    logic                 start_frame;
    logic                 complete;
    logic                 false_start;

    // 2-of-3 majority of the three mid-bit samples
    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity check: odd mode wants XOR(data, p) = 1, even mode wants 0
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (PARITY_MODE == 1) ? ~x : x;
    endfunction

    assign rx_s       = sync2;
    assign tick       = (div_cnt == DIV_LAST);
    assign vote       = majority(vote_a, vote_b, rx_s);
    assign vote_pt    = tick && (s_cnt == S_VOTE_C);
    assign bit_end    = tick && (s_cnt == S_END);
    assign busy       = (state != IDLE);
    assign flag_state = state;

    // Two-flop synchroniser on the asynchronous serial line
    always_ff @(posedge system_clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_data;
            sync2 <= sync1;
        end
    end

    // Oversampling tick divider, re-phased to the start-bit falling edge
    always_ff @(posedge system_clk) begin
        if (rst || start_frame || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge system_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic and frame-level strobes
    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        complete    = 1'b0;
        false_start = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    next_state  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (vote_pt && vote) begin
                    next_state  = IDLE;
                    false_start = 1'b1;
                end else if (bit_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == DATA_LAST)) begin
                    next_state = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (vote_pt && (bit_cnt == STOP_LAST)) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Sample counter within a bit, plus the two early majority samples
    always_ff @(posedge system_clk) begin
        if (rst || start_frame || (state == IDLE)) begin
            s_cnt <= '0;
        end else if (tick) begin
            s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + S_W'(1);
        end
        if (tick && (s_cnt == S_VOTE_A)) begin
            vote_a <= rx_s;
        end
        if (tick && (s_cnt == S_VOTE_B)) begin
            vote_b <= rx_s;
        end
    end

    // Bit counter: data bits in DATA, stop bits in STOP
    always_ff @(posedge system_clk) begin
        if (rst || start_frame) begin
            bit_cnt <= '0;
        end else if (bit_end) begin
            if (next_state != state) begin
                bit_cnt <= '0;
            end else if ((state == DATA) || (state == STOP)) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Payload shift register (LSB first) and per-frame error accumulators
    always_ff @(posedge system_clk) begin
        if (vote_pt && (state == DATA)) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
        end
        if (rst || start_frame) begin
            par_bad  <= 1'b0;
            ferr_acc <= 1'b0;
        end else if (vote_pt) begin
            if (state == PARITY) begin
                par_bad <= parity_mismatch(shreg, vote);
            end
            if ((state == STOP) && !vote) begin
                ferr_acc <= 1'b1;
            end
        end
    end

    // Start qualifier: after any frame ends the line must be seen high in IDLE
    always_ff @(posedge system_clk) begin
        if (rst || complete || false_start) begin
            armed <= 1'b0;
        end else if ((state == IDLE) && rx_s) begin
            armed <= 1'b1;
        end
    end

    // Output registers, updated in the frame-completion cycle
    always_ff @(posedge system_clk) begin
        if (rst) begin
            data_out   <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= complete;
            if (complete) begin
                data_out   <= shreg;
                parity_err <= par_bad;
                frame_err  <= ferr_acc | ~vote;
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_acc;

    // Break tracker: stays set while every data/parity/stop vote is 0
    always_ff @(posedge system_clk) begin
        if (rst) begin
            zero_acc  <= 1'b0;
            break_det <= 1'b0;
        end else begin
            if (start_frame) begin
                zero_acc <= 1'b1;
            end else if (vote_pt && vote && (state != START)) begin
                zero_acc <= 1'b0;
            end
            break_det <= complete && zero_acc && !vote;
        end
    end
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: DIV = 1, 16 clocks per bit.
// dut_a is 8N1, dut_b is 8E1 (even parity).
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_a;
    logic       line_b;

    logic [7:0] data_a, data_b;
    logic       done_a, done_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;
    logic [2:0] flag_a, flag_b;
    logic       brk_a, brk_b;

    int checks   = 0;
    int failures = 0;

    int   cnt_a = 0;
    int   cnt_b = 0;
    int   stray_brk = 0;
    logic [7:0] hist_a [0:31];
    logic [7:0] last_data_a, last_data_b;
    logic       last_perr_a, last_perr_b;
    logic       last_ferr_a, last_ferr_b;
    logic       last_brk_a;
    logic       busy_smp;

    always #5 clk = ~clk;

    uart_rx_oversampled #(
        .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
    ) dut_a (
        .system_clk(clk), .rst(rst), .rx_data(line_a),
        .data_out(data_a), .rx_done(done_a), .parity_err(perr_a),
        .frame_err(ferr_a), .busy(busy_a), .flag_state(flag_a),
        .break_det(brk_a)
    );

    uart_rx_oversampled #(
        .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)
    ) dut_b (
        .system_clk(clk), .rst(rst), .rx_data(line_b),
        .data_out(data_b), .rx_done(done_b), .parity_err(perr_b),
        .frame_err(ferr_b), .busy(busy_b), .flag_state(flag_b),
        .break_det(brk_b)
    );

    // Capture outputs on each rx_done pulse, sampled on the falling edge
    always @(negedge clk) begin
        if (done_a) begin
            hist_a[cnt_a % 32] <= data_a;
            last_data_a <= data_a;
            last_perr_a <= perr_a;
            last_ferr_a <= ferr_a;
            last_brk_a  <= brk_a;
            cnt_a <= cnt_a + 1;
        end
        if (done_b) begin
            last_data_b <= data_b;
            last_perr_b <= perr_b;
            last_ferr_b <= ferr_b;
            cnt_b <= cnt_b + 1;
        end
        if ((brk_a && !done_a) || (brk_b && !done_b)) begin
            stray_brk <= stray_brk + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input int unit, input logic v);
        if (unit == 0) line_a = v;
        else           line_b = v;
        repeat (8) @(negedge clk);
        busy_smp = (unit == 0) ? busy_a : busy_b;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input int unit, input logic [7:0] d, input bit has_par,
                              input logic p, input logic stop, output logic [15:0] mask);
        int k;
        mask = '0;
        k = 0;
        drive_bit(unit, 1'b0);
        mask[k] = busy_smp; k++;
        for (int i = 0; i < 8; i++) begin
            drive_bit(unit, d[i]);
            mask[k] = busy_smp; k++;
        end
        if (has_par) begin
            drive_bit(unit, p);
            mask[k] = busy_smp; k++;
        end
        drive_bit(unit, stop);
        mask[k] = busy_smp;
        if (unit == 0) line_a = 1'b1;
        else           line_b = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m;
        int base;

        rst    = 1'b1;
        line_a = 1'b1;
        line_b = 1'b1;
        idle_cycles(5);

        // Reset state
        chk("rst_data",  data_a, 0);
        chk("rst_done",  done_a, 0);
        chk("rst_perr",  perr_a, 0);
        chk("rst_ferr",  ferr_a, 0);
        chk("rst_busy",  busy_a, 0);
        chk("rst_state", flag_a, 0);
        chk("rst_brk",   brk_a, 0);
        rst = 1'b0;
        idle_cycles(20);

        // 1: 0xA5, 8N1
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, m);
        idle_cycles(20);
        chk("t1_count", cnt_a, 1);
        chk("t1_data",  last_data_a, 8'hA5);
        chk("t1_perr",  last_perr_a, 0);
        chk("t1_ferr",  last_ferr_a, 0);
        chk("t1_busy",  m, 16'h03FF);

        // 2: even parity, 0x07 with p=1 (good) then p=0 (bad)
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, m);
        idle_cycles(20);
        chk("t2_count1", cnt_b, 1);
        chk("t2_perr_ok", last_perr_b, 0);
        chk("t2_data1", last_data_b, 8'h07);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, m);
        idle_cycles(20);
        chk("t2_count2", cnt_b, 2);
        chk("t2_perr_bad", last_perr_b, 1);
        chk("t2_data2", data_b, 8'h07);
        chk("t2_ferr", last_ferr_b, 0);

        // 3: 4-clock low glitch is a false start
        line_a = 1'b0;
        idle_cycles(4);
        line_a = 1'b1;
        idle_cycles(2);
        chk("t3_in_start", flag_a, 1);
        idle_cycles(30);
        chk("t3_idle", flag_a, 0);
        chk("t3_count", cnt_a, 1);
        chk("t3_data", data_a, 8'hA5);
        chk("t3_ferr", ferr_a, 0);

        // 4: 0x3C with stop bit 0, line then held low 40 clocks
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, m);
        line_a = 1'b0;
        idle_cycles(40);
        chk("t4_count", cnt_a, 2);
        chk("t4_data", last_data_a, 8'h3C);
        chk("t4_ferr", last_ferr_a, 1);
        chk("t4_idle_low", flag_a, 0);
        line_a = 1'b1;
        idle_cycles(200);
        chk("t4_no_spurious", cnt_a, 2);

        // 5: back-to-back 0x11, 0xEE
        base = cnt_a;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, m);
        send_frame(0, 8'hEE, 1'b0, 1'b0, 1'b1, m);
        idle_cycles(20);
        chk("t5_count", cnt_a, base + 2);
        chk("t5_first", hist_a[base % 32], 8'h11);
        chk("t5_second", hist_a[(base + 1) % 32], 8'hEE);
        chk("t5_ferr", last_ferr_a, 0);

        // 6: break, 12 bit times low
        base = cnt_a;
        line_a = 1'b0;
        idle_cycles(192);
        line_a = 1'b1;
        idle_cycles(40);
        chk("t6_count", cnt_a, base + 1);
        chk("t6_data", last_data_a, 0);
        chk("t6_ferr", last_ferr_a, 1);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("t6_brk", last_brk_a, 1);
`else
        chk("t6_brk", last_brk_a, 0);
`endif
        idle_cycles(200);
        chk("t6_no_spurious", cnt_a, base + 1);
        chk("stray_brk", stray_brk, 0);

        // Reset mid-frame aborts without rx_done
        base = cnt_a;
        line_a = 1'b0;
        idle_cycles(60);
        chk("mr_busy_before", busy_a, 1);
        rst = 1'b1;
        idle_cycles(2);
        line_a = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(200);
        chk("mr_count", cnt_a, base);
        chk("mr_state", flag_a, 0);
        chk("mr_data", data_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Parametrised UART receiver with its own oversampling tick generator, configurable frame format and per-frame error reporting. It is the successor to the fixed 8N1 receiver-plus-baud-generator pair. It adds majority-vote sampling, false-start rejection, optional parity, and 1 or 2 stop bits. It sits between the RX pin and the byte consumer; downstream logic captures data on the single-cycle rx_done strobe.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, >= 8
DATA_BITS, 8, payload bits per frame, 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
system_clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_data  in  1  asynchronous serial line; idle high
data_out  out  DATA_BITS  last received payload; held until the next rx_done
rx_done  out  1  one-cycle pulse when a frame completes (good or bad)
parity_err  out  1  parity status of the last frame; valid with rx_done, held
frame_err  out  1  stop-bit status of the last frame (any stop sampled 0); held
busy  out  1  high in every state except IDLE
flag_state  out  3  current FSM state encoding, for debug
break_det  out  1  break strobe (see Optional Feature)

Behaviour:
- Reset: synchronous on rst high. All outputs 0, FSM to IDLE, tick counter 0, synchroniser flops to 1. Reset mid-frame aborts the frame with no rx_done.
- Input path: 2-flop synchroniser on rx_data. Only the synchronised signal is used.
- Tick: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated, minimum 1. A free counter 0..DIV-1 produces a one-cycle tick at DIV-1. The counter is reset to 0 on the IDLE->START transition so sampling phase aligns to the falling edge.
- Sampling: sample counter s runs 0..OVERSAMPLE-1 per bit on ticks. Samples are taken at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided at s = OVERSAMPLE/2+1.
- FSM states and flag_state encodings: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4.
- IDLE -> START: synchronised line goes low.
- START: if the voted bit is 1, the start is false; return to IDLE with no strobe and no error. If 0, go to DATA at end of bit (s = OVERSAMPLE-1).
- DATA: shift LSB first, DATA_BITS bits. Then go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: odd mode requires XOR(data, p) = 1; even mode requires XOR(data, p) = 0. A mismatch sets the parity_err value for this frame.
- STOP: STOP_BITS bits. A 0 vote on any stop bit sets frame_err for this frame.
- Frame completion: at the vote point of the last stop bit (not end of bit), in one cycle:
  - data_out, parity_err and frame_err update;
  - rx_done pulses;
  - FSM returns to IDLE. This allows back-to-back frames with a short stop bit.
- A frame with frame_err still delivers data_out and rx_done; downstream decides.
- Line low on return to IDLE (framing error or break): no new start is accepted until the line has been high for at least one system_clk cycle.
- Latency: rx_done occurs (1 + DATA_BITS + P + STOP_BITS - 1) bit times + OVERSAMPLE/2+1 ticks after the falling edge, plus 2 synchroniser cycles. P = 1 if parity is enabled, else 0.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined: break_det pulses for one cycle together with rx_done when all data bits, the parity bit (if present) and all stop bits are sampled 0. In that case frame_err = 1 and data_out = 0 as normal. Receiver then waits in IDLE for line high, per the rule above.
- Not defined: break_det is tied to 0 and no detection logic is built.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV = 1, bit = 16 clocks), 8N1 unless noted.
1. Send 0xA5 -> one rx_done; data_out = 0xA5; parity_err = 0; frame_err = 0; busy high throughout the frame.
2. PARITY_MODE=2: send 0x07 with p=1 -> parity_err = 0. Send 0x07 with p=0 -> parity_err = 1, data_out = 0x07.
3. Low glitch of 4 clocks on idle line -> FSM returns to IDLE from START; no rx_done; outputs unchanged.
4. Send 0x3C with stop bit = 0 -> rx_done; data_out = 0x3C; frame_err = 1. Line then held low 40 clocks, then high -> no spurious frame.
5. Two frames 0x11 and 0xEE back-to-back, no idle gap -> two rx_done pulses; data_out = 0x11 then 0xEE.
6. With UART_RX_BREAK_DETECT_EN: hold line low for 12 bit times -> break_det = 1 and frame_err = 1 on the same cycle as rx_done; data_out = 0x00. Without the macro, break_det stays 0.
